// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   tx_state_e   : arbiter FSM state encoding
//   BAUD_DIV_DEF : default clk cycles per baud tick
//   START_TO_DEF : default clk cycles allowed for the transmitter to go busy after a load
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD       = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } tx_state_e;

   localparam int unsigned BAUD_DIV_DEF = 160;
   localparam int unsigned START_TO_DEF = 320;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider.
//   clk  : clock
//   rst  : synchronous active-high reset, counter returns to 0
//   tick : one-cycle pulse while the counter sits at BAUD_DIV-1
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned   CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)                cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                    cnt_q <= cnt_q + CW'(1);
   end

   // Gated by rst so the pulse is also suppressed on the very first reset cycle.
   assign tick = (cnt_q == LAST) && !rst;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART transmitter.
//   clk, rst       : clock, synchronous active-high reset
//   req, req_byte  : per-requester pending level and byte (requester i on [8i+7:8i])
//   grant          : one-hot, one-cycle acknowledge; the byte is consumed that cycle
//   tx_enable      : baud tick to the transmitter
//   tx_din_rdy     : one-cycle load strobe, one cycle after grant
//   tx_din_byte    : registered byte presented to the transmitter
//   tx_uart_ready  : transmitter idle indication
//   busy           : FSM is not idle
//   last_src       : index of the most recently granted requester
//   err            : sticky flag, transmitter never went busy after a load
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
   parameter int unsigned START_TO = START_TO_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_byte,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       tx_enable,
   output logic                       tx_din_rdy,
   output logic [7:0]                 tx_din_byte,
   input  logic                       tx_uart_ready,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] last_src,
   output logic                       err
);

   localparam int unsigned   SW      = $clog2(NUM_REQ);
   localparam int unsigned   TW      = $clog2(START_TO + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(START_TO - 1);
   localparam logic [SW-1:0] SRC_RST = SW'(NUM_REQ - 1);

   tx_state_e          state_q;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               din_rdy_q;
   logic [7:0]         din_byte_q, din_byte_d;
   logic [SW-1:0]      last_src_q, win_d;
   logic               win_vld_d;
   logic               err_q;
   logic [TW-1:0]      to_cnt_q;

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .tick (tx_enable)
   );

   // Round-robin pick: requesters above last_src take priority, then wrap to
   // the low indices (including last_src itself, which ranks lowest).
   always_comb begin
      win_d     = '0;
      win_vld_d = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_vld_d && req[i] && (i > 32'(last_src_q))) begin
            win_vld_d = 1'b1;
            win_d     = SW'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_vld_d && req[i] && (i <= 32'(last_src_q))) begin
            win_vld_d = 1'b1;
            win_d     = SW'(i);
         end
      end
      grant_d    = win_vld_d ? (NUM_REQ'(1) << win_d) : '0;
      din_byte_d = req_byte[{win_d, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         din_rdy_q  <= 1'b0;
         din_byte_q <= 8'h00;
         last_src_q <= SRC_RST;
         err_q      <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         grant_q   <= '0;
         din_rdy_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Grant is registered, so it is visible during LOAD.
               if (win_vld_d && tx_uart_ready) begin
                  grant_q    <= grant_d;
                  din_byte_q <= din_byte_d;
                  last_src_q <= win_d;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               din_rdy_q <= 1'b1;
               to_cnt_q  <= '0;
               state_q   <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (!tx_uart_ready) begin
                  state_q <= ST_WAIT_DONE;
               end else if (to_cnt_q == TO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + TW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (tx_uart_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign tx_din_rdy  = din_rdy_q;
   assign tx_din_byte = din_byte_q;
   assign busy        = (state_q != ST_IDLE);
   assign last_src    = last_src_q;
   assign err         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int BD  = 160;
   localparam int STO = 320;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [8*NR-1:0] req_byte = '0;
   logic [NR-1:0]   grant;
   logic            tx_enable, tx_din_rdy, busy, err;
   logic [7:0]      tx_din_byte;
   logic            tx_uart_ready = 1'b1;
   logic [1:0]      last_src;

   uart_tx_arbiter #(.NUM_REQ(NR), .BAUD_DIV(BD), .START_TO(STO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_byte      (req_byte),
      .grant         (grant),
      .tx_enable     (tx_enable),
      .tx_din_rdy    (tx_din_rdy),
      .tx_din_byte   (tx_din_byte),
      .tx_uart_ready (tx_uart_ready),
      .busy          (busy),
      .last_src      (last_src),
      .err           (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int since_rst = 0;
   bit baud_chk = 1'b0;
   int en_cnt = 0;
   int lg = NR - 1;
   bit exp_rdy = 1'b0;
   logic [7:0] exp_byte = 8'h00;
   int gap = 100;
   int n_grant = 0, n_sent = 0;
   int order[$];
   int tx_hold = 0, frame_len = 4;
   bit tx_stuck = 1'b0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester at or after from+1, modulo NR.
   function automatic int rr_pick(logic [NR-1:0] r, int from);
      for (int k = 1; k <= NR; k++)
         if (r[(from + k) % NR]) return (from + k) % NR;
      return -1;
   endfunction

   // One clock: sample outputs 1 time unit after the edge, check the monitor
   // rules, then let requesters and the transmitter model react.
   task automatic step();
      logic [NR-1:0] req_b;
      logic rdy_b, rst_b;
      int w;
      req_b = req; rdy_b = tx_uart_ready; rst_b = rst;
      @(posedge clk); #1;
      since_rst = rst_b ? 1 : since_rst + 1;
      gap++;
      if (rst_b) begin lg = NR - 1; exp_rdy = 1'b0; end
      if (tx_enable) en_cnt++;
      if (baud_chk) chk("tx_enable", tx_enable, 32'(since_rst % BD == 0));
      chk("grant_rdy_excl", (|grant) & tx_din_rdy, 0);
      chk("din_rdy", tx_din_rdy, exp_rdy);
      if (exp_rdy) chk("din_byte", tx_din_byte, exp_byte);
      if (tx_din_rdy) n_sent++;
      exp_rdy = 1'b0;
      if (grant != '0) begin
         w = rr_pick(req_b, lg);
         chk("grant_onehot", $onehot(grant), 1);
         chk("grant_pick", grant, (w < 0) ? 0 : (1 << w));
         chk("grant_tx_ready", rdy_b, 1);
         chk("grant_gap", gap >= 3, 1);
         if (w >= 0) begin
            chk("last_src", last_src, w);
            exp_byte = req_byte[8*w +: 8];
            exp_rdy  = 1'b1;
            lg       = w;
            order.push_back(w);
            req[w]   = 1'b0;
            n_grant++;
         end
         gap = 0;
      end
      if (tx_hold > 0) begin
         tx_hold--;
         if (tx_hold == 0) tx_uart_ready = 1'b1;
      end
      if (tx_din_rdy && !tx_stuck) begin
         tx_uart_ready = 1'b0;
         tx_hold       = frame_len;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(); step();
      chk("rst_grant", grant, 0);
      chk("rst_din_rdy", tx_din_rdy, 0);
      chk("rst_din_byte", tx_din_byte, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_last_src", last_src, NR - 1);
      chk("rst_err", err, 0);
      chk("rst_tx_enable", tx_enable, 0);
      rst = 1'b0;
      baud_chk = 1'b1;
   endtask

   task automatic wait_grants(int n, int budget, string tag);
      int target, c;
      target = n_grant + n;
      c = 0;
      while (n_grant < target && c < budget) begin step(); c++; end
      chk({tag, "_grant_timeout"}, n_grant >= target, 1);
   endtask

   task automatic wait_idle(int budget, string tag);
      int c;
      c = 0;
      while ((busy || !tx_uart_ready) && c < budget) begin step(); c++; end
      chk({tag, "_idle_timeout"}, busy, 0);
   endtask

   initial begin
      int en0, g0, n_req_made, c;

      // Reset and idle: baud pulses at 160 and 320, no grants or loads.
      do_reset();
      en0 = en_cnt;
      repeat (400) step();
      chk("idle_en_pulses", en_cnt - en0, 2);
      chk("idle_busy", busy, 0);

      // Single requester with byte AA.
      frame_len = 6;
      req_byte[7:0] = 8'hAA;
      req = 4'b0001;
      wait_grants(1, 20, "single");
      chk("single_src", order[$], 0);
      chk("single_busy_grant", busy, 1);
      step();
      chk("single_din_rdy", tx_din_rdy, 1);
      chk("single_byte", tx_din_byte, 8'hAA);
      chk("single_busy_load", busy, 1);
      wait_idle(40, "single");

      // All four requesting: order 0,1,2,3,0.
      do_reset();
      order.delete();
      req_byte = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      wait_grants(1, 20, "rr");
      req_byte[7:0] = 8'h55;
      req[0] = 1'b1;
      wait_grants(4, 200, "rr");
      chk("rr_len", order.size(), 5);
      if (order.size() == 5) begin
         chk("rr_0", order[0], 0);
         chk("rr_1", order[1], 1);
         chk("rr_2", order[2], 2);
         chk("rr_3", order[3], 3);
         chk("rr_4", order[4], 0);
      end
      wait_idle(60, "rr");

      // Wrap: after granting 2, requests on 0 and 2 go to 0 first.
      req_byte[23:16] = 8'h77;
      req = 4'b0100;
      wait_grants(1, 40, "wrap");
      chk("wrap_first", order[$], 2);
      req_byte[7:0]   = 8'h0A;
      req_byte[23:16] = 8'h2B;
      req = 4'b0101;
      wait_grants(1, 60, "wrap");
      chk("wrap_next", order[$], 0);
      wait_grants(1, 60, "wrap");
      chk("wrap_after", order[$], 2);
      wait_idle(60, "wrap");

      // Transmitter never goes busy: err after START_TO cycles in WAIT_START.
      tx_stuck = 1'b1;
      req_byte[15:8] = 8'h5A;
      req = 4'b0010;
      wait_grants(1, 20, "to");
      step();
      chk("to_din_rdy", tx_din_rdy, 1);
      repeat (STO - 1) step();
      chk("to_err_before", err, 0);
      chk("to_busy_before", busy, 1);
      step();
      chk("to_err_set", err, 1);
      chk("to_busy_after", busy, 0);
      tx_stuck = 1'b0;
      repeat (50) step();
      chk("to_err_sticky", err, 1);
      req_byte[31:24] = 8'hC3;
      req = 4'b1000;
      wait_grants(1, 20, "to2");
      wait_idle(60, "to2");
      chk("to_err_sticky2", err, 1);
      do_reset();

      // Reset during WAIT_DONE aborts the frame; next request served normally.
      frame_len = 30;
      req_byte[7:0] = 8'h99;
      req = 4'b0001;
      wait_grants(1, 20, "mid");
      repeat (5) step();
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_last_src", last_src, 3);
      chk("mid_grant", grant, 0);
      chk("mid_din_rdy", tx_din_rdy, 0);
      req_byte[15:8] = 8'h3C;
      req = 4'b0010;
      wait_grants(1, 80, "mid");
      chk("mid_src", order[$], 1);
      step();
      chk("mid_din_rdy2", tx_din_rdy, 1);
      chk("mid_byte", tx_din_byte, 8'h3C);
      wait_idle(60, "mid");

      // Random arrivals against the monitor's round-robin and delivery rules.
      g0 = n_grant;
      n_req_made = 0;
      for (int t = 0; t < 4000; t++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && $urandom_range(7) == 0) begin
               req[i] = 1'b1;
               req_byte[8*i +: 8] = 8'($urandom);
               n_req_made++;
            end
         end
         frame_len = $urandom_range(12, 2);
         step();
      end
      c = 0;
      while (req != '0 && c < 3000) begin step(); c++; end
      chk("rand_drain", req, 0);
      wait_idle(60, "rand");
      chk("rand_all_granted", n_grant - g0, n_req_made);
      chk("bytes_delivered_once", n_sent, n_grant);
      chk("final_err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
